// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage with handshaked data-memory port and MEM/WB register
module mem_access_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic        memwrite_in,
  input  logic        memread_in,
  input  logic [2:0]  funct3_in,
  input  logic [63:0] alu_in,
  input  logic [63:0] store_in,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [7:0]  dmem_be,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [63:0] dmem_rdata,
  output logic        stall,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic [63:0] wb_alu,
  output logic [63:0] wb_load,
  output logic [4:0]  wb_rd,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} stateType;
  stateType state;

  logic [CW-1:0] waitCnt;
  logic [2:0]    reqF3;
  logic [2:0]    reqOff;
  logic          reqRegwrite;
  logic          reqMemtoreg;
  logic [4:0]    reqRd;
  logic [63:0]   reqAlu;

  logic       isMem, isWrite, sizeOk, aligned, accept, timeoutHit;
  logic [2:0] off;
  logic [7:0] baseBe;
  logic [63:0] shifted, loadExt;

  assign off = alu_in[2:0];

  always_comb begin
    isMem   = memread_in | memwrite_in;
    isWrite = memwrite_in & ~memread_in;
    // Unsigned sizes exist only for loads; 111 is never a valid access.
    sizeOk  = (funct3_in != 3'b111) && !(isWrite && funct3_in[2]);
    aligned = 1'b1;
    baseBe  = 8'h01;
    case (funct3_in[1:0])
      2'b00: begin aligned = 1'b1;             baseBe = 8'h01; end
      2'b01: begin aligned = ~off[0];          baseBe = 8'h03; end
      2'b10: begin aligned = (off[1:0] == 2'b00); baseBe = 8'h0F; end
      default: begin aligned = (off == 3'b000); baseBe = 8'hFF; end
    endcase
    accept = isMem & sizeOk & aligned;
  end

  always_comb begin
    shifted = dmem_rdata >> {reqOff, 3'b000};
    case (reqF3)
      3'b000:  loadExt = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  loadExt = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  loadExt = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  loadExt = {56'd0, shifted[7:0]};
      3'b101:  loadExt = {48'd0, shifted[15:0]};
      3'b110:  loadExt = {32'd0, shifted[31:0]};
      default: loadExt = shifted;
    endcase
  end

  assign timeoutHit = (waitCnt == LAST_WAIT);

  // The timeout cycle releases the stall so upstream does not re-present the aborted op.
  always_comb begin
    if (state == IDLE) stall = accept;
    else               stall = ~dmem_ready & ~timeoutHit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      waitCnt     <= '0;
      reqF3       <= '0;
      reqOff      <= '0;
      reqRegwrite <= 1'b0;
      reqMemtoreg <= 1'b0;
      reqRd       <= '0;
      reqAlu      <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_alu      <= '0;
      wb_load     <= '0;
      wb_rd       <= '0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= BUSY;
            waitCnt     <= '0;
            dmem_req    <= 1'b1;
            dmem_we     <= isWrite;
            dmem_addr   <= {alu_in[63:3], 3'b000};
            dmem_be     <= baseBe << off;
            dmem_wdata  <= store_in << {off, 3'b000};
            reqF3       <= funct3_in;
            reqOff      <= off;
            reqRegwrite <= regwrite_in;
            reqMemtoreg <= memtoreg_in;
            reqRd       <= rd_in;
            reqAlu      <= alu_in;
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
          end else begin
            wb_regwrite <= regwrite_in & ~isMem;
            wb_memtoreg <= memtoreg_in & ~isMem;
            wb_alu      <= alu_in;
            wb_rd       <= rd_in;
            wb_load     <= '0;
            misalign    <= isMem;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            state       <= IDLE;
            waitCnt     <= '0;
            dmem_req    <= 1'b0;
            wb_regwrite <= reqRegwrite & ~dmem_we;
            wb_memtoreg <= reqMemtoreg & ~dmem_we;
            wb_alu      <= reqAlu;
            wb_rd       <= reqRd;
            wb_load     <= loadExt;
          end else if (timeoutHit) begin
            state       <= IDLE;
            waitCnt     <= '0;
            dmem_req    <= 1'b0;
            bus_err     <= 1'b1;
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_alu      <= reqAlu;
            wb_rd       <= reqRd;
            wb_load     <= '0;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_in, memtoreg_in, memwrite_in, memread_in;
  logic [2:0]  funct3_in;
  logic [63:0] alu_in, store_in;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;
  logic        stall, wb_regwrite, wb_memtoreg;
  logic [63:0] wb_alu, wb_load;
  logic [4:0]  wb_rd;
  logic        misalign, bus_err;

  int checkCount = 0;
  int errCount = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
    .memwrite_in(memwrite_in), .memread_in(memread_in),
    .funct3_in(funct3_in), .alu_in(alu_in), .store_in(store_in), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_alu(wb_alu), .wb_load(wb_load), .wb_rd(wb_rd),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic rw, input logic m2r, input logic mw, input logic mr,
                       input logic [2:0] f3, input logic [63:0] alu,
                       input logic [63:0] st, input logic [4:0] rd);
    regwrite_in = rw;
    memtoreg_in = m2r;
    memwrite_in = mw;
    memread_in  = mr;
    funct3_in   = f3;
    alu_in      = alu;
    store_in    = st;
    rd_in       = rd;
    #1;
  endtask

  task automatic setNop();
    setOp(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 5'd0);
  endtask

  // One load that completes on its first BUSY cycle.
  task automatic runLoad(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] rdata, input logic [63:0] expLoad);
    dmem_rdata = rdata;
    setOp(1'b1, 1'b1, 1'b0, 1'b1, f3, addr, 64'd0, 5'd7);
    checkValue({tag, "_stall0"}, stall, 1);
    step();
    checkValue({tag, "_req"}, dmem_req, 1);
    checkValue({tag, "_addr"}, dmem_addr, {addr[63:3], 3'b000});
    checkValue({tag, "_bubble"}, wb_regwrite, 0);
    dmem_ready = 1'b1;
    #1;
    checkValue({tag, "_stall1"}, stall, 0);
    step();
    setNop();
    dmem_ready = 1'b0;
    checkValue({tag, "_load"}, wb_load, expLoad);
    checkValue({tag, "_rw"}, wb_regwrite, 1);
    checkValue({tag, "_rd"}, wb_rd, 7);
    checkValue({tag, "_reqoff"}, dmem_req, 0);
  endtask

  initial begin
    reset = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    setNop();
    step();
    step();
    reset = 1'b0;
    #1;
    checkValue("rst_req", dmem_req, 0);
    checkValue("rst_wb_rw", wb_regwrite, 0);
    checkValue("rst_wb_alu", wb_alu, 0);
    checkValue("rst_stall", stall, 0);
    checkValue("rst_misalign", misalign, 0);
    checkValue("rst_bus_err", bus_err, 0);

    // Plain ALU op behaves as a pipeline register.
    setOp(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 5'd5);
    checkValue("alu_stall", stall, 0);
    step();
    setNop();
    checkValue("alu_wb_alu", wb_alu, 64'h1234);
    checkValue("alu_wb_rd", wb_rd, 5);
    checkValue("alu_wb_rw", wb_regwrite, 1);
    checkValue("alu_req", dmem_req, 0);

    runLoad("lb", 3'b000, 64'h1003, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
    runLoad("lbu", 3'b100, 64'h1003, 64'h00000000_80000000, 64'h80);
    runLoad("lw", 3'b010, 64'h4004, 64'h87654321_00000000, 64'hFFFFFFFF_87654321);
    runLoad("lhu", 3'b101, 64'h4006, 64'h9ABC0000_00000000, 64'h9ABC);
    runLoad("ld", 3'b011, 64'h4008, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);

    // Halfword store into the top lane; store never writes back.
    setOp(1'b1, 1'b0, 1'b1, 1'b0, 3'b001, 64'h2006, 64'hBEEF, 5'd3);
    checkValue("sh_stall0", stall, 1);
    step();
    checkValue("sh_be", dmem_be, 8'hC0);
    checkValue("sh_wdata", dmem_wdata, 64'hBEEF0000_00000000);
    checkValue("sh_we", dmem_we, 1);
    checkValue("sh_addr", dmem_addr, 64'h2000);
    dmem_ready = 1'b1;
    step();
    setNop();
    dmem_ready = 1'b0;
    checkValue("sh_wb_rw", wb_regwrite, 0);
    checkValue("sh_req", dmem_req, 0);

    // One-cycle-late ready stretches the access by one cycle.
    dmem_rdata = 64'h00000000_0000FF7F;
    setOp(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 64'h4000, 64'd0, 5'd9);
    step();
    checkValue("late_stall", stall, 1);
    step();
    checkValue("late_req", dmem_req, 1);
    checkValue("late_bubble", wb_regwrite, 0);
    dmem_ready = 1'b1;
    #1;
    checkValue("late_stall_rel", stall, 0);
    step();
    setNop();
    dmem_ready = 1'b0;
    checkValue("late_load", wb_load, 64'hFFFFFFFF_FFFFFF7F);
    checkValue("late_rw", wb_regwrite, 1);

    // Misaligned word load.
    setOp(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 64'h3002, 64'd0, 5'd4);
    checkValue("mis_stall", stall, 0);
    step();
    setNop();
    checkValue("mis_pulse", misalign, 1);
    checkValue("mis_req", dmem_req, 0);
    checkValue("mis_rw", wb_regwrite, 0);
    step();
    checkValue("mis_pulse_end", misalign, 0);

    // Unsigned-size store is illegal even when aligned.
    setOp(1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 64'h3000, 64'h55, 5'd0);
    checkValue("ill_st_stall", stall, 0);
    step();
    setNop();
    checkValue("ill_st_pulse", misalign, 1);
    checkValue("ill_st_req", dmem_req, 0);

    // Timeout: ready never arrives.
    setOp(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 64'h5000, 64'd0, 5'd6);
    step();
    for (int i = 0; i < 4; i++) begin
      checkValue("to_req", dmem_req, 1);
      checkValue("to_bus_err_low", bus_err, 0);
      if (i < 3) checkValue("to_stall", stall, 1);
      step();
    end
    setNop();
    checkValue("to_bus_err", bus_err, 1);
    checkValue("to_req_drop", dmem_req, 0);
    checkValue("to_stall_drop", stall, 0);
    checkValue("to_wb_rw", wb_regwrite, 0);
    step();
    checkValue("to_bus_err_end", bus_err, 0);

    // Reset in the middle of an access; the late ready must be ignored.
    setOp(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 64'h6000, 64'd0, 5'd8);
    step();
    checkValue("rb_req", dmem_req, 1);
    reset = 1'b1;
    dmem_ready = 1'b1;
    setNop();
    step();
    reset = 1'b0;
    #1;
    checkValue("rb_req_drop", dmem_req, 0);
    checkValue("rb_wb_alu", wb_alu, 0);
    checkValue("rb_wb_rd", wb_rd, 0);
    checkValue("rb_wb_load", wb_load, 0);
    checkValue("rb_stall", stall, 0);
    step();
    checkValue("rb_ready_ignored", dmem_req, 0);
    checkValue("rb_wb_rw", wb_regwrite, 0);
    dmem_ready = 1'b0;
    setOp(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 64'hABCD, 64'd0, 5'd0);
    checkValue("rb_idle_stall", stall, 0);
    step();
    setNop();
    checkValue("rb_idle_alu", wb_alu, 64'hABCD);
    checkValue("rb_idle_rd0", wb_rd, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 64-bit five-stage pipeline. It sits directly downstream of the EX/MEM pipeline register and upstream of write-back. It turns the registered ALU result and store data into handshaked requests on the data-memory port, with aligned byte enables. Load data is extracted and sign- or zero-extended. Results go into an internal MEM/WB register, and the block raises a stall to freeze upstream stages while an access is outstanding.

## Interface
- TIMEOUT, 64: max cycles waiting for `dmem_ready` before the access is aborted.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- regwrite_in, memtoreg_in, memwrite_in, memread_in  in  1 each  control bits from EX/MEM.
- funct3_in  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
- alu_in  in  64  address (memory ops) or result (others).
- store_in  in  64  store data, low bytes significant.
- rd_in  in  5  destination register.
- dmem_req  out  1  registered request strobe.
- dmem_we  out  1  1 = write.
- dmem_addr  out  64  `{alu_in[63:3],3'b000}`.
- dmem_be  out  8  byte enables.
- dmem_wdata  out  64  store data shifted to its byte lane.
- dmem_ready  in  1  access complete; `dmem_rdata` is valid in the same cycle.
- dmem_rdata  in  64  read doubleword.
- stall  out  1  combinational; upstream holds its inputs while high.
- wb_regwrite, wb_memtoreg  out  1  registered control to write-back.
- wb_alu, wb_load  out  64  registered ALU result and extended load data.
- wb_rd  out  5  registered destination.
- misalign  out  1  one-cycle pulse: misaligned address or illegal size.
- bus_err  out  1  one-cycle pulse: access timed out.

## Operation
- A memory op is `memread_in | memwrite_in`. If both bits are set, it is treated as a read.
- Offset `off = alu_in[2:0]`. An access is aligned when:
  - halfword: `off[0]=0`
  - word: `off[1:0]=0`
  - doubleword: `off=0`
- Stores are illegal for funct3 1xx. Any funct3 111 is illegal.
- Illegal or misaligned memory op:
  - no request is issued and there is no stall;
  - `misalign` pulses next cycle;
  - `wb_regwrite=0`.
- Store lanes: `dmem_be` is 0x01, 0x03, 0x0F or 0xFF shifted left by `off`. `dmem_wdata = store_in << (8*off)`.
- Load extraction: `sh = dmem_rdata >> (8*off)`. Take the low 8/16/32/64 bits, sign-extended for 000/001/010 and zero-extended for 100/101/110.
- FSM states:
  - IDLE
    - non-memory op: capture into the wb_* registers next edge.
    - aligned memory op: stall=1, latch the request, go to BUSY (`dmem_req=1` from the next cycle).
  - BUSY
    - `dmem_ready=1`: stall=0, load the wb_* registers (`wb_load` from the extracted data; for stores `wb_regwrite=0`), clear `dmem_req`, go to IDLE.
    - otherwise stall=1 and the wait counter increments.
    - counter reaches TIMEOUT-1 without ready: go to IDLE, drop `dmem_req`, pulse `bus_err`, and load wb_* with `wb_regwrite=0`.
- While stall=1, wb_* holds a bubble (`wb_regwrite=0`, `wb_memtoreg=0`).
- `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` are registered when the request is latched and stay stable while `dmem_req=1`.
- Rd=0 is passed through unchanged; write-back discards it.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
  - A reset during BUSY drops `dmem_req` at that edge and abandons the access.
  - A `dmem_ready` arriving afterwards is ignored.
- Non-memory op: 1-cycle latency, equivalent to a plain pipeline register.
- Memory op, cycle by cycle:
  - cycle 0: op presented, stall=1.
  - cycle 1: `dmem_req=1`. With `dmem_ready` in this cycle, stall=0.
  - cycle 2: wb_* valid.
  - Minimum latency is 2 cycles. Each cycle `dmem_ready` is late adds 1.
- `dmem_ready` while not in BUSY is ignored.
- Back-to-back memory ops: the next op is seen in IDLE at the cycle after completion. `dmem_req` deasserts for at least 1 cycle between accesses.
- Timeout: `bus_err` pulses in the cycle after the TIMEOUT-th waiting cycle.

## Test plan
- ALU op with `alu_in=0x1234`, rd=5, regwrite=1 -> next cycle `wb_alu=0x1234`, `wb_rd=5`, `wb_regwrite=1`, no `dmem_req`, stall never high.
- LB at addr 0x1003, `dmem_rdata=0x00000000_80000000`, ready on the first BUSY cycle:
  - `dmem_addr=0x1000`, stall high for exactly 1 cycle;
  - `wb_load=0xFFFFFFFFFFFFFF80`.
  - Same access with LBU -> `wb_load=0x80`.
- SH at addr 0x2006, `store_in=0xBEEF` -> `dmem_be=0xC0`, `dmem_wdata=0xBEEF000000000000`, `dmem_we=1`, `wb_regwrite=0`.
- LW at addr 0x3002 -> `misalign` pulses, no `dmem_req`, `wb_regwrite=0`, no stall.
- LD with `dmem_ready` held low and TIMEOUT=4:
  - `dmem_req` high for 4 cycles, then `bus_err` pulses and stall drops;
  - `wb_regwrite=0`.
- Reset asserted during BUSY, then `dmem_ready=1` -> `dmem_req=0` after the reset edge, all wb_* outputs 0, ready ignored, state IDLE.
